// File: rtl/crop_window.sv
// Crops the live pixel stream to a CROP_W x CROP_H window whose start column
// is latched from iXSTART at the first pixel of every frame.
module crop_window #(
    parameter int DW      = 10,
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480,
    parameter int CROP_W  = 320,
    parameter int CROP_H  = 190,
    parameter int YSTART  = 51
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iDVAL,
    input  logic [DW-1:0] iDATA,
    input  logic [15:0]   iXSTART,
    output logic          oDVAL,
    output logic [DW-1:0] oDATA,
    output logic          oSOF,
    output logic          oEOL,
    output logic          oEOF,
    output logic [15:0]   oXUSED
);

    localparam logic [15:0] X_MAX  = 16'(FRAME_W - 1);
    localparam logic [15:0] Y_MAX  = 16'(FRAME_H - 1);
    localparam logic [15:0] XS_MAX = 16'(FRAME_W - CROP_W);
    localparam logic [15:0] CW_M1  = 16'(CROP_W - 1);
    localparam logic [15:0] Y_LO   = 16'(YSTART);
    localparam logic [15:0] Y_HI   = 16'(YSTART + CROP_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        CROP,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] x_cnt;
    logic [15:0] y_cnt;
    logic [15:0] xs_reg;
    logic [15:0] xs_clamp;
    logic [15:0] xs_eff;
    logic [15:0] x_hi;
    logic        first;
    logic        x_wrap;
    logic        y_wrap;
    logic        in_win;
    logic        at_start;
    logic        at_eol;
    logic        at_last;
    logic        out_en;

    assign xs_clamp = (iXSTART > XS_MAX) ? XS_MAX : iXSTART;
    assign first    = (x_cnt == 16'd0) && (y_cnt == 16'd0);
    // The latching pixel already crops with the freshly clamped start.
    assign xs_eff   = first ? xs_clamp : xs_reg;
    assign x_hi     = xs_eff + CW_M1;
    assign in_win   = (x_cnt >= xs_eff) && (x_cnt <= x_hi)
                   && (y_cnt >= Y_LO) && (y_cnt <= Y_HI);
    assign at_start = (y_cnt == Y_LO) && (x_cnt == xs_eff);
    assign at_eol   = in_win && (x_cnt == x_hi);
    assign at_last  = at_eol && (y_cnt == Y_HI);
    assign x_wrap   = (x_cnt == X_MAX);
    assign y_wrap   = x_wrap && (y_cnt == Y_MAX);

    always_comb begin
        state_nx = state;
        out_en   = 1'b0;
        if (iDVAL) begin
            case (state)
                IDLE: begin
                    if (at_start) begin
                        out_en = 1'b1;
                        if (at_last) state_nx = y_wrap ? IDLE : DONE;
                        else         state_nx = CROP;
                    end
                end
                CROP: begin
                    out_en = in_win;
                    if (at_last) state_nx = y_wrap ? IDLE : DONE;
                end
                DONE: begin
                    if (y_wrap) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state  <= IDLE;
            x_cnt  <= 16'd0;
            y_cnt  <= 16'd0;
            xs_reg <= 16'd0;
            oXUSED <= 16'd0;
        end else if (iDVAL) begin
            state <= state_nx;
            if (first) begin
                xs_reg <= xs_clamp;
                oXUSED <= xs_clamp;
            end
            if (x_wrap) begin
                x_cnt <= 16'd0;
                y_cnt <= (y_cnt == Y_MAX) ? 16'd0 : y_cnt + 16'd1;
            end else begin
                x_cnt <= x_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDVAL <= 1'b0;
            oDATA <= '0;
            oSOF  <= 1'b0;
            oEOL  <= 1'b0;
            oEOF  <= 1'b0;
        end else begin
            oDVAL <= out_en;
            oSOF  <= out_en && at_start;
            oEOL  <= out_en && at_eol;
            oEOF  <= out_en && at_last;
            if (out_en) oDATA <= iDATA;
        end
    end

endmodule
